// File: rtl/sprite_plotter.sv
// Bitmap sprite plotter: walks an SPR_W x SPR_H mask one pixel per clock and
// issues a VGA-adapter plot for every set bit, with optional erase and edge clipping.
module sprite_plotter #(
   parameter int SPR_W     = 16,
   parameter int SPR_H     = 16,
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int COL_W     = 3,
   parameter int BG_COLOUR = 0,
   parameter int CLIP      = 1,
   parameter int X_MAX     = 160,
   parameter int Y_MAX     = 120
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [X_W-1:0]         x,
   input  logic [Y_W-1:0]         y,
   input  logic [COL_W-1:0]       colour,
   input  logic                   erase,
   input  logic [SPR_W*SPR_H-1:0] bitmap,
   output logic [X_W-1:0]         xout,
   output logic [Y_W-1:0]         yout,
   output logic [COL_W-1:0]       colour_out,
   output logic                   plot,
   output logic                   busy,
   output logic                   done
);

   localparam int N  = SPR_W * SPR_H;
   localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] FIN  = 2'd2;

   localparam logic [COL_W-1:0] BG    = COL_W'(BG_COLOUR);
   localparam logic [X_W:0]     X_LIM = (X_W+1)'(X_MAX);
   localparam logic [Y_W:0]     Y_LIM = (Y_W+1)'(Y_MAX);
   localparam logic [CW-1:0]    COL_LAST = CW'(SPR_W - 1);
   localparam logic [RW-1:0]    ROW_LAST = RW'(SPR_H - 1);

   logic [1:0]       state;
   logic [CW-1:0]    col;
   logic [RW-1:0]    row;

   logic [X_W-1:0]   x_p0;
   logic [Y_W-1:0]   y_p0;
   logic [COL_W-1:0] colour_p0;
   logic [N-1:0]     bmp_p0;

   logic [X_W:0]     xs;
   logic [Y_W:0]     ys;
   logic             col_end;
   logic             last;
   logic             vis;

   // Sums carry one extra bit so a pixel past the right/bottom edge is visible
   // to the clip test instead of silently wrapping onto the screen.
   function automatic logic on_screen(input logic [X_W:0] xs_i,
                                      input logic [Y_W:0] ys_i);
      if (CLIP == 0)
         return 1'b1;
      return (xs_i < X_LIM) && (ys_i < Y_LIM);
   endfunction

   assign xs      = {1'b0, x_p0} + (X_W+1)'(col);
   assign ys      = {1'b0, y_p0} + (Y_W+1)'(row);
   assign col_end = (col == COL_LAST);
   assign last    = col_end && (row == ROW_LAST);
   assign vis     = bmp_p0[0] && on_screen(xs, ys);

   // Stage p0: sprite parameters captured at start; the mask shifts so the
   // current pixel is always bit 0.
   always_ff @(posedge clk) begin
      if (state == IDLE && start) begin
         x_p0      <= x;
         y_p0      <= y;
         colour_p0 <= erase ? BG : colour;
         bmp_p0    <= bitmap;
      end else if (state == SCAN) begin
         bmp_p0    <= bmp_p0 >> 1;
      end
   end

   // Output stage: one pixel registered per SCAN cycle, then a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         col        <= '0;
         row        <= '0;
         xout       <= '0;
         yout       <= '0;
         colour_out <= '0;
         plot       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               plot <= 1'b0;
               busy <= 1'b0;
               done <= 1'b0;
               if (start) begin
                  col   <= '0;
                  row   <= '0;
                  state <= SCAN;
               end
            end
            SCAN: begin
               busy <= 1'b1;
               done <= 1'b0;
               plot <= vis;
               if (vis) begin
                  xout       <= xs[X_W-1:0];
                  yout       <= ys[Y_W-1:0];
                  colour_out <= colour_p0;
               end
               if (col_end) begin
                  col <= '0;
                  row <= row + RW'(1);
               end else begin
                  col <= col + CW'(1);
               end
               if (last)
                  state <= FIN;
            end
            FIN: begin
               plot  <= 1'b0;
               busy  <= 1'b1;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: begin
               plot  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sprite_plotter.sv
// Directed bench for sprite_plotter: three instances (4x4 clipped, 4x4 wrapping,
// 16x16 clipped) driven with hand-chosen sprites and checked cycle by cycle.
module tb_sprite_plotter;

   logic         clk;
   logic         reset;
   logic [2:0]   start_v;
   logic [7:0]   x_i;
   logic [6:0]   y_i;
   logic [2:0]   col_i;
   logic         er_i;
   logic [255:0] bm;

   logic [7:0]   xo  [3];
   logic [6:0]   yo  [3];
   logic [2:0]   co  [3];
   logic         po  [3];
   logic         bo  [3];
   logic         dn  [3];

   int           sel;
   int           n_vec;
   int           n_bad;

   sprite_plotter #(.SPR_W(4), .SPR_H(4), .CLIP(1)) u_clip4 (
      .clk(clk), .reset(reset), .start(start_v[0]), .x(x_i), .y(y_i),
      .colour(col_i), .erase(er_i), .bitmap(bm[15:0]),
      .xout(xo[0]), .yout(yo[0]), .colour_out(co[0]),
      .plot(po[0]), .busy(bo[0]), .done(dn[0]));

   sprite_plotter #(.SPR_W(4), .SPR_H(4), .CLIP(0)) u_wrap4 (
      .clk(clk), .reset(reset), .start(start_v[1]), .x(x_i), .y(y_i),
      .colour(col_i), .erase(er_i), .bitmap(bm[15:0]),
      .xout(xo[1]), .yout(yo[1]), .colour_out(co[1]),
      .plot(po[1]), .busy(bo[1]), .done(dn[1]));

   sprite_plotter #(.SPR_W(16), .SPR_H(16), .CLIP(1)) u_clip16 (
      .clk(clk), .reset(reset), .start(start_v[2]), .x(x_i), .y(y_i),
      .colour(col_i), .erase(er_i), .bitmap(bm),
      .xout(xo[2]), .yout(yo[2]), .colour_out(co[2]),
      .plot(po[2]), .busy(bo[2]), .done(dn[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Start held high until the last sprite's done cycle, so extra starts
   // during busy must be ignored. Cycle c is sampled after the c-th edge
   // following the start edge.
   task automatic run_seq(input int s, input int nspr, input logic [255:0] bmp,
                          input int xa, input int ya, input int xb, input int yb,
                          input int colr, input int er, input string nm);
      int w, clip, n, total, plots, eplots, sp, j, k, ox, oy, xs, ys, ev, ecol;
      w      = (s == 2) ? 16 : 4;
      clip   = (s == 1) ? 0 : 1;
      n      = w * w;
      total  = nspr * (n + 2);
      plots  = 0;
      eplots = 0;
      ecol   = (er != 0) ? 0 : colr;
      @(negedge clk);
      sel   = s;
      bm    = bmp;
      x_i   = 8'(xa);
      y_i   = 7'(ya);
      col_i = 3'(colr);
      er_i  = (er != 0);
      start_v[s] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      x_i = 8'(xb);
      y_i = 7'(yb);
      for (int c = 1; c <= total; c++) begin
         @(posedge clk);
         @(negedge clk);
         sp = c / (n + 2);
         j  = c % (n + 2);
         ox = (sp == 0) ? xa : xb;
         oy = (sp == 0) ? ya : yb;
         ev = 0;
         if (j >= 1 && j <= n) begin
            k  = j - 1;
            xs = ox + (k % w);
            ys = oy + (k / w);
            ev = int'(bmp[k]);
            if (clip != 0 && (xs >= 160 || ys >= 120))
               ev = 0;
            xs = xs % 256;
            ys = ys % 128;
         end
         eplots += ev;
         if (po[s]) plots++;
         chk($sformatf("%s c%0d plot", nm, c), int'(po[s]), ev);
         chk($sformatf("%s c%0d busy", nm, c), int'(bo[s]), (j != 0) ? 1 : 0);
         chk($sformatf("%s c%0d done", nm, c), int'(dn[s]), (j == n + 1) ? 1 : 0);
         if (ev != 0 && po[s]) begin
            chk($sformatf("%s c%0d x", nm, c), int'(xo[s]), xs);
            chk($sformatf("%s c%0d y", nm, c), int'(yo[s]), ys);
            chk($sformatf("%s c%0d colour", nm, c), int'(co[s]), ecol);
         end
         if (c == total - 1)
            start_v[s] = 1'b0;
      end
      chk($sformatf("%s plot count", nm), plots, eplots);
   endtask

   initial begin
      logic [255:0] b;
      n_vec   = 0;
      n_bad   = 0;
      sel     = 0;
      reset   = 1'b1;
      start_v = 3'b000;
      x_i     = '0;
      y_i     = '0;
      col_i   = '0;
      er_i    = 1'b0;
      bm      = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst%0d plot", i), int'(po[i]), 0);
         chk($sformatf("rst%0d busy", i), int'(bo[i]), 0);
         chk($sformatf("rst%0d done", i), int'(dn[i]), 0);
         chk($sformatf("rst%0d xout", i), int'(xo[i]), 0);
         chk($sformatf("rst%0d yout", i), int'(yo[i]), 0);
         chk($sformatf("rst%0d colour", i), int'(co[i]), 0);
      end
      reset = 1'b0;

      run_seq(0, 1, 256'h8001, 10, 20, 77, 33, 6, 0, "basic");
      run_seq(0, 1, 256'h8001, 10, 20, 77, 33, 6, 1, "erase");
      run_seq(0, 1, 256'hFFFF, 158, 118, 0, 0, 5, 0, "clip");
      run_seq(1, 1, 256'hFFFF, 254, 126, 0, 0, 3, 0, "wrap");
      run_seq(0, 1, 256'h0000, 30, 40, 0, 0, 7, 0, "empty");
      run_seq(0, 2, 256'hA5C3, 10, 20, 40, 60, 2, 0, "b2b");

      // Abort a 16x16 scan with reset after cycle 5.
      @(negedge clk);
      sel   = 2;
      bm    = '1;
      x_i   = 8'd0;
      y_i   = 7'd0;
      col_i = 3'd5;
      er_i  = 1'b0;
      start_v[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[2] = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk);
         @(negedge clk);
      end
      chk("abort pre plot", int'(po[2]), 1);
      chk("abort pre x", int'(xo[2]), 4);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("abort plot", int'(po[2]), 0);
      chk("abort busy", int'(bo[2]), 0);
      chk("abort done", int'(dn[2]), 0);
      for (int c = 0; c < 4; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("abort idle%0d plot", c), int'(po[2]), 0);
         chk($sformatf("abort idle%0d done", c), int'(dn[2]), 0);
         chk($sformatf("abort idle%0d busy", c), int'(bo[2]), 0);
      end

      b      = '0;
      b[0]   = 1'b1;
      b[17]  = 1'b1;
      b[130] = 1'b1;
      b[255] = 1'b1;
      run_seq(2, 1, b, 100, 50, 3, 3, 4, 0, "after_abort");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
